// File: rtl/carousel_multi_round.sv
// carousel_multi_round: gathers one word per lane, then re-presents the batch
// for ROUNDS rounds, rotating it across lanes between rounds.
module carousel_multi_round #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int ROUNDS = 4,
   parameter int STEP = 1,
   parameter bit DIR = 1'b0,
   localparam int RW = ROUNDS > 1 ? $clog2(ROUNDS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LANES*WIDTH-1:0] data_in,
   input  logic [LANES-1:0]       data_in_valid,
   output logic [LANES-1:0]       data_in_ready,
   output logic [LANES*WIDTH-1:0] data_out,
   output logic [LANES-1:0]       data_out_valid,
   input  logic [LANES-1:0]       data_out_ready,
   output logic [RW-1:0]          round_idx,
   output logic                   batch_done
);
   typedef enum logic {FILL, PRESENT} state_t;
   localparam int OFF = DIR ? (LANES - STEP % LANES) % LANES : STEP % LANES;
   localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);
   state_t state_q, state_d;
   logic [WIDTH-1:0] regs_q [LANES];
   logic [WIDTH-1:0] regs_d [LANES];
   logic [LANES-1:0] holding_q, holding_d, in_fire, out_fire;
   logic [RW-1:0] round_q, round_d;
   logic done_q, done_d;
   always_comb begin
      in_fire = state_q == FILL ? data_in_valid & ~holding_q : '0;
      out_fire = state_q == PRESENT ? holding_q & data_out_ready : '0;
      state_d = state_q;
      regs_d = regs_q;
      round_d = round_q;
      done_d = 1'b0;
      holding_d = state_q == FILL ? holding_q | in_fire : holding_q & ~out_fire;
      for (int i = 0; i < LANES; i++)
         if (in_fire[i]) regs_d[i] = data_in[i*WIDTH +: WIDTH];
      if (state_q == FILL && &holding_d) begin
         state_d = PRESENT;
      end else if (state_q == PRESENT && holding_d == '0) begin
         if (round_q != LAST) begin
            // lane i takes the word of lane i+OFF, OFF already folding in DIR
            for (int i = 0; i < LANES; i++)
               regs_d[i] = regs_q[(i + OFF) % LANES];
            round_d = round_q + RW'(1);
            holding_d = '1;
         end else begin
            round_d = '0;
            state_d = FILL;
            done_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         holding_q <= '0;
         round_q <= '0;
         done_q <= 1'b0;
         for (int i = 0; i < LANES; i++)
            regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         holding_q <= holding_d;
         round_q <= round_d;
         done_q <= done_d;
         regs_q <= regs_d;
      end
   end
   for (genvar g = 0; g < LANES; g++) begin : g_out
      assign data_out[g*WIDTH +: WIDTH] = regs_q[g];
   end
   assign data_in_ready = state_q == FILL ? ~holding_q : '0;
   assign data_out_valid = state_q == PRESENT ? holding_q : '0;
   assign round_idx = round_q;
   assign batch_done = done_q;
endmodule

// File: tb/tb_carousel_multi_round.sv
// tb_carousel_multi_round: scoreboard bench for the default carousel plus two
// free-running instances covering reverse/step-2 and single-round setups.
module tb_carousel_multi_round;
   localparam int W = 8, L = 4, R = 4, S = 1, D = 0;
   localparam int XR [2] = '{3, 1};
   localparam int XS [2] = '{2, 0};
   localparam int XD [2] = '{1, 0};
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   logic [L*W-1:0] din, dout;
   logic [L-1:0] vin, rin, vout, rout;
   logic [1:0] ridx;
   logic done;
   logic [L*W-1:0] x_din [2];
   logic [L*W-1:0] x_dout [2];
   logic [L-1:0] x_rin [2];
   logic [L-1:0] x_vout [2];
   logic x_done [2];
   logic [1:0] a_ridx;
   logic b_ridx;
   int checks = 0, fails = 0;
   carousel_multi_round #(.WIDTH(W), .LANES(L), .ROUNDS(R), .STEP(S), .DIR(D)) dut (
      .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin), .data_in_ready(rin),
      .data_out(dout), .data_out_valid(vout), .data_out_ready(rout),
      .round_idx(ridx), .batch_done(done));
   carousel_multi_round #(.WIDTH(W), .LANES(L), .ROUNDS(3), .STEP(2), .DIR(1)) dut_a (
      .clk(clk), .rst(rst), .data_in(x_din[0]), .data_in_valid({L{1'b1}}), .data_in_ready(x_rin[0]),
      .data_out(x_dout[0]), .data_out_valid(x_vout[0]), .data_out_ready({L{1'b1}}),
      .round_idx(a_ridx), .batch_done(x_done[0]));
   carousel_multi_round #(.WIDTH(W), .LANES(L), .ROUNDS(1), .STEP(0), .DIR(0)) dut_b (
      .clk(clk), .rst(rst), .data_in(x_din[1]), .data_in_valid({L{1'b1}}), .data_in_ready(x_rin[1]),
      .data_out(x_dout[1]), .data_out_valid(x_vout[1]), .data_out_ready({L{1'b1}}),
      .round_idx(b_ridx), .batch_done(x_done[1]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Round r of a batch: DIR 0 lane i shows word (i + r*step), DIR 1 word (i - r*step), mod L.
   function automatic logic [L*W-1:0] rotv(input logic [L*W-1:0] v, input int r, input int st, input int dr);
      logic [L*W-1:0] o;
      for (int i = 0; i < L; i++) begin
         int s;
         s = dr != 0 ? (((i - r*st) % L) + L) % L : (i + r*st) % L;
         o[i*W +: W] = v[s*W +: W];
      end
      return o;
   endfunction

   logic [W-1:0] mq [L][$];
   logic [L-1:0] have = '0;
   logic [L*W-1:0] capv = '0;
   bit exp_done = 1'b0;
   always @(negedge clk) begin : mon
      int mx, left;
      logic [L-1:0] ev, er;
      logic [L*W-1:0] rv;
      if (!rst) begin
         for (int i = 0; i < L; i++) mq[i].delete();
         have = '0;
         exp_done = 1'b0;
      end else begin
         mx = 0;
         for (int i = 0; i < L; i++) if (mq[i].size() > mx) mx = mq[i].size();
         for (int i = 0; i < L; i++) ev[i] = mx > 0 && mq[i].size() == mx;
         er = mx > 0 ? '0 : ~have;
         chk("batch_done", done, exp_done);
         exp_done = 1'b0;
         chk("in_ready", rin, er);
         chk("out_valid", vout, ev);
         chk("round_idx", ridx, mx > 0 ? R - mx : 0);
         for (int i = 0; i < L; i++) if (ev[i]) chk("data_out", dout[i*W +: W], mq[i][0]);
         if (mx > 0) begin
            for (int i = 0; i < L; i++) if (ev[i] && rout[i]) void'(mq[i].pop_front());
            left = 0;
            for (int i = 0; i < L; i++) left += mq[i].size();
            exp_done = left == 0;
         end else begin
            for (int i = 0; i < L; i++)
               if (vin[i] && !have[i]) begin
                  capv[i*W +: W] = din[i*W +: W];
                  have[i] = 1'b1;
               end
            if (&have) begin
               for (int r = 0; r < R; r++) begin
                  rv = rotv(capv, r, S, D);
                  for (int i = 0; i < L; i++) mq[i].push_back(rv[i*W +: W]);
               end
               have = '0;
            end
         end
      end
   end

   logic [L*W-1:0] xq [2][$];
   int xr [2][$];
   bit xdone [2] = '{1'b0, 1'b0};
   always @(negedge clk) begin : xmon
      int ri;
      for (int k = 0; k < 2; k++) begin
         ri = k == 0 ? int'(a_ridx) : int'(b_ridx);
         if (!rst) begin
            xq[k].delete();
            xr[k].delete();
            xdone[k] = 1'b0;
         end else begin
            chk("alt_done", x_done[k], xdone[k]);
            xdone[k] = 1'b0;
            if (xq[k].size() > 0) begin
               chk("alt_valid", x_vout[k], {L{1'b1}});
               chk("alt_ready", x_rin[k], 0);
               chk("alt_data", x_dout[k], xq[k][0]);
               chk("alt_round", ri, xr[k][0]);
               void'(xq[k].pop_front());
               void'(xr[k].pop_front());
               xdone[k] = xq[k].size() == 0;
            end else begin
               chk("alt_valid", x_vout[k], 0);
               chk("alt_ready", x_rin[k], {L{1'b1}});
               chk("alt_round", ri, 0);
               for (int r = 0; r < XR[k]; r++) begin
                  xq[k].push_back(rotv(x_din[k], r, XS[k], XD[k]));
                  xr[k].push_back(r);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      x_din[0] = $urandom;
      x_din[1] = $urandom;
   endtask

   initial begin
      int left;
      vin = '1;
      din = 32'hDEADBEEF;
      rout = '1;
      x_din[0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      x_din[1] = {8'h08, 8'h07, 8'h06, 8'h05};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", rin, 4'hF);
      chk("rst_out_valid", vout, 0);
      chk("rst_data_out", dout, 0);
      chk("rst_round_idx", ridx, 0);
      chk("rst_batch_done", done, 0);
      rst = 1'b1;
      vin = '0;
      din = {8'h13, 8'h12, 8'h11, 8'h10};
      vin = '1;
      step();
      vin = '0;
      repeat (R + 2) step();
      for (int c = 1; c <= 8; c++) begin
         vin = c == 1 ? 4'b0100 : c == 3 ? 4'b0001 : c == 4 ? 4'b1000 :
               c == 5 ? 4'b0001 : c == 7 ? 4'b0010 : 4'b0000;
         din = c == 5 ? {8'h23, 8'h22, 8'h21, 8'hEE} : {8'h23, 8'h22, 8'h21, 8'h20};
         step();
      end
      vin = '0;
      repeat (R + 2) step();
      din = {8'h13, 8'h12, 8'h11, 8'h10};
      vin = '1;
      step();
      vin = '0;
      step();
      rout = 4'b1011;
      repeat (5) step();
      rout = '1;
      repeat (R + 2) step();
      din = {8'h13, 8'h12, 8'h11, 8'h10};
      vin = '1;
      step();
      vin = '0;
      step();
      step();
      rout = 4'b0011;
      step();
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", vout, 0);
      chk("mid_rst_round_idx", ridx, 0);
      chk("mid_rst_batch_done", done, 0);
      chk("mid_rst_in_ready", rin, 4'hF);
      @(posedge clk);
      #1;
      rst = 1'b1;
      rout = '1;
      din = {8'h04, 8'h03, 8'h02, 8'h01};
      vin = '1;
      step();
      vin = '0;
      repeat (R + 2) step();
      for (int n = 0; n < 400; n++) begin
         vin = L'($urandom);
         din = $urandom;
         rout = L'($urandom);
         step();
      end
      vin = '0;
      rout = '1;
      repeat (3 * R) step();
      left = 0;
      for (int i = 0; i < L; i++) left += mq[i].size();
      chk("drained", left, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/carousel_multi_round.md
# carousel_multi_round

Multi-lane gather-and-rotate buffer: collects one word per lane from `LANES` independent valid/ready inputs, then presents the captured batch on `LANES` independent valid/ready outputs for `ROUNDS` consecutive rounds. Between rounds the batch is rotated across lanes by a configurable step and direction. It serves the carousel-style data-exchange paths where each lane must see every other lane's word in turn.

## Interface
- `WIDTH`, 8, bits per lane word
- `LANES`, 4, number of lanes (>= 2)
- `ROUNDS`, 4, presentations per batch (>= 1)
- `STEP`, 1, lanes rotated per round (0 .. LANES-1; 0 = re-present unchanged)
- `DIR`, 0, 0: lane i takes lane (i+STEP) mod LANES; 1: lane i takes lane (i-STEP) mod LANES
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `data_in`  in  WIDTH x LANES  per-lane input word
- `data_in_valid`  in  1 x LANES  per-lane input valid
- `data_in_ready`  out  1 x LANES  per-lane input ready
- `data_out`  out  WIDTH x LANES  per-lane output word
- `data_out_valid`  out  1 x LANES  per-lane output valid
- `data_out_ready`  in  1 x LANES  per-lane output ready
- `round_idx`  out  RW  current round, RW = ROUNDS>1 ? $clog2(ROUNDS) : 1
- `batch_done`  out  1  one-cycle pulse after the last round is fully consumed

## Operation
- Storage: `regs[LANES]` (WIDTH each), `holding[LANES]`, state (FILL, PRESENT), round counter, `batch_done` flop.
- FILL: `data_in_ready[i] = !holding[i]`. The lane captures on `data_in_valid[i] && data_in_ready[i]` and sets `holding[i]`. Lanes fill in any order and any number per cycle. `data_out_valid` is all 0.
- FILL -> PRESENT at the edge after which all `holding` bits are 1, including when the last lanes are captured on that same edge. `round_idx` = 0.
- PRESENT: `data_in_ready` is all 0. `data_out_valid[i] = holding[i]` and `data_out[i] = regs[i]`. A handshake on `data_out_valid[i] && data_out_ready[i]` clears `holding[i]`.
- Round end: the round ends when `(holding & ~out_fire) == 0` at an edge. Lanes consumed in the same cycle count together.
  - If `round_idx < ROUNDS-1`: at that edge, rotate `regs` per `STEP`/`DIR`, increment `round_idx`, set all `holding` bits, and stay in PRESENT.
  - Else: at that edge, clear `holding`, set `round_idx` to 0, go to FILL, and set `batch_done` for exactly one cycle.
- `data_out_valid` never depends on `data_out_ready`. `data_in_ready` never depends on `data_in_valid`.
- The width and data of `regs` pass through unmodified; no arithmetic is applied to data.
- Reset (`rst` = 0, async):
  - state = FILL, `holding` = 0, `regs` = 0, `round_idx` = 0, `batch_done` = 0.
  - Therefore `data_out_valid` = 0, `data_out` = 0 and `data_in_ready` = all 1, but no capture occurs while `rst` = 0.
  - Reset mid-batch discards all captured and pending data immediately.

## Timing
- Capture: the word is registered at the handshake edge.
- Fill-to-present latency: outputs are valid on the cycle after the edge that completed the fill.
- Round-to-round: rotated data is valid on the cycle after the final consuming edge. There are no bubble cycles beyond that single edge.
- With all inputs valid and all outputs ready, one batch takes 1 + ROUNDS cycles: 1 fill cycle plus ROUNDS present cycles.
- `batch_done` is high during the first FILL cycle after the batch. The new fill may capture in that same cycle.
- Per-lane backpressure: a stalled lane holds `data_out[i]` and `data_out_valid[i]` stable until its handshake. Consumed lanes stay low until the round advances.

## Test plan
- Full batch, defaults, all ready:
  - Stimulus: fill 0x10, 0x11, 0x12, 0x13 in one cycle.
  - Required outputs: round 0 = {10,11,12,13}, round 1 = {11,12,13,10}, round 2 = {12,13,10,11}, round 3 = {13,10,11,12}.
  - `round_idx` 0..3 on consecutive cycles, then `batch_done` pulses once, then `data_in_ready` = 1111.
- Staggered fill:
  - Stimulus: lanes 2, 0, 3, 1 valid on cycles 1, 3, 4, 7; lane 0 asserts valid again on cycle 5.
  - Required: lane 0 is not re-captured on cycle 5 (ready already low). Outputs are valid starting cycle 8.
- Per-lane backpressure:
  - Stimulus: in round 1, lane 2 ready held low for 5 cycles while the others are ready.
  - Required: lanes 0, 1, 3 valid drop after one cycle. Lane 2 holds 0x13 stable. Round 2 starts the cycle after lane 2 is consumed.
- Direction and step:
  - Stimulus: DIR=1, STEP=2, LANES=4, ROUNDS=3, fill {A0,A1,A2,A3}.
  - Required: rounds present {A0,A1,A2,A3}, {A2,A3,A0,A1}, {A0,A1,A2,A3}.
- Degenerate configuration:
  - Stimulus: ROUNDS=1, STEP=0, fill {5,6,7,8}.
  - Required: a single presentation of {5,6,7,8}, then `batch_done`. `round_idx` stays 0.
- Reset mid-operation:
  - Stimulus: assert `rst` = 0 asynchronously (off clock edge) during round 2 with two lanes still pending.
  - Required: `data_out_valid` = 0, `round_idx` = 0 and `batch_done` = 0 immediately. After release, a fresh fill of {1,2,3,4} presents {1,2,3,4} in round 0.
